ysyx_25060170_pipe_stage: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake on both sides, an optional two-entry skid buffer, flush, and a discarded-entry counter. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/LS, LS/WB) with one block instantiated at every stage boundary. The fetch-side instance uses the reset-payload parameters to present the boot instruction/PC immediately out of reset.

---
 rtl/ysyx_25060170_pipe_stage_pkg.sv | 13 +
 rtl/ysyx_25060170_pipe_stage_if.sv | 8 +
 rtl/ysyx_25060170_sat_cnt.sv | 21 ++
 rtl/ysyx_25060170_pipe_stage.sv | 84 ++++++++
 tb/tb_ysyx_25060170_pipe_stage.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25060170_pipe_stage_pkg.sv
// ysyx_25060170_pipe_stage_pkg: shared state encoding, payload layout and boot constants
package ysyx_25060170_pipe_stage_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;
  localparam int IF_ID_W = $bits(if_id_t);
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  function automatic logic [1:0] occ_of(state_e s);
    return s == ST_FULL ? 2'd2 : s == ST_ONE ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/ysyx_25060170_pipe_stage_if.sv
// ysyx_25060170_pipe_stage_if: valid/ready/data handshake bundle between pipeline stages
interface ysyx_25060170_pipe_stage_if #(parameter int DW = ysyx_25060170_pipe_stage_pkg::IF_ID_W);
  logic valid;
  logic ready;
  logic [DW-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/ysyx_25060170_sat_cnt.sv
// ysyx_25060170_sat_cnt: saturating accumulator, adds inc when en, clamps at all-ones
module ysyx_25060170_sat_cnt #(
  parameter int W  = 32,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [IW-1:0] inc,
  output logic [W-1:0]  cnt
);
  localparam int SW = W + IW;
  logic [W-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum;
  always_comb begin
    sum = SW'(cnt_q) + SW'(inc);
    cnt_d = !en ? cnt_q : |sum[SW-1:W] ? '1 : sum[W-1:0];
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/ysyx_25060170_pipe_stage.sv
// ysyx_25060170_pipe_stage: handshake pipeline register with optional skid entry, flush and drop counter
module ysyx_25060170_pipe_stage
  import ysyx_25060170_pipe_stage_pkg::*;
#(
  parameter int             DW        = IF_ID_W,
  parameter bit             SKID      = 1'b1,
  parameter bit             RST_VALID = 1'b0,
  parameter logic [DW-1:0]  RST_DATA  = '0,
  parameter int             CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_25060170_pipe_stage_if.slave    in_if,
  ysyx_25060170_pipe_stage_if.master   out_if,
  input  logic                         flush,
  output logic [1:0]                   occupancy,
  output logic [CNT_W-1:0]             flush_cnt
);
  state_e state_q, state_d;
  logic [DW-1:0] main_q, main_d, skid_q, skid_d;
  logic in_ready, in_fire, out_fire;
  assign out_if.valid = state_q != ST_EMPTY;
  assign out_if.data = main_q;
  assign in_if.ready = in_ready;
  assign in_fire = in_if.valid & in_ready;
  assign out_fire = out_if.valid & out_if.ready;
  assign occupancy = occ_of(state_q);
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d = '0;
      skid_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_ONE;
          main_d = in_if.data;
        end
        ST_ONE: if (in_fire && out_fire) main_d = in_if.data;
        else if (in_fire) begin
          state_d = ST_FULL;
          skid_d = in_if.data;
        end else if (out_fire) state_d = ST_EMPTY;
        ST_FULL: if (out_fire) begin
          state_d = ST_ONE;
          main_d = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? (RST_VALID ? ST_ONE : ST_EMPTY) : state_d;
    main_q <= rst ? RST_DATA : main_d;
  end
  generate
    if (SKID) begin : g_skid
      // in_ready is its own flop so out_ready never reaches upstream combinationally
      logic in_ready_q;
      logic [DW-1:0] skid_r;
      always_ff @(posedge clk) begin
        skid_r <= rst ? '0 : skid_d;
        in_ready_q <= rst ? 1'b1 : state_d != ST_FULL;
      end
      assign skid_q = skid_r;
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      logic unused_skid;
      assign unused_skid = ^skid_d;
      assign skid_q = '0;
      assign in_ready = !out_if.valid | out_if.ready;
    end
  endgenerate
  ysyx_25060170_sat_cnt #(.W(CNT_W), .IW(2)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush),
    .inc (occupancy - 2'(out_fire) + 2'(in_fire)),
    .cnt (flush_cnt)
  );
endmodule

// File: tb/tb_ysyx_25060170_pipe_stage.sv
// tb_ysyx_25060170_pipe_stage: scoreboard bench for skid and non-skid stage instances
module tb_ysyx_25060170_pipe_stage;
  import ysyx_25060170_pipe_stage_pkg::*;
  localparam logic [63:0] RST_D = {32'h0, RST_PC};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ysyx_25060170_pipe_stage_if #(.DW(64)) s_in ();
  ysyx_25060170_pipe_stage_if #(.DW(64)) s_out ();
  ysyx_25060170_pipe_stage_if #(.DW(64)) z_in ();
  ysyx_25060170_pipe_stage_if #(.DW(64)) z_out ();
  logic s_flush, z_flush;
  logic [1:0] s_occ, z_occ, z_cnt;
  logic [31:0] s_cnt;
  int n_cmp = 0, n_bad = 0, n_pop = 0;
  logic [63:0] q[$];

  ysyx_25060170_pipe_stage #(.DW(64), .SKID(1), .RST_VALID(1), .RST_DATA(RST_D), .CNT_W(32)) u_skid (
    .clk(clk), .rst(rst), .in_if(s_in), .out_if(s_out), .flush(s_flush), .occupancy(s_occ), .flush_cnt(s_cnt)
  );
  ysyx_25060170_pipe_stage #(.DW(64), .SKID(0), .RST_VALID(0), .RST_DATA('0), .CNT_W(2)) u_noskid (
    .clk(clk), .rst(rst), .in_if(z_in), .out_if(z_out), .flush(z_flush), .occupancy(z_occ), .flush_cnt(z_cnt)
  );

  // scoreboard for the skid instance: push on accept, pop on consume, clear on flush
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      q.push_back(RST_D);
    end else begin
      if (s_out.valid && s_out.ready) begin
        n_cmp++;
        n_pop++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_pop: got %h, required no output (queue empty)", s_out.data);
        end else begin
          if (s_out.data !== q[0]) begin
            n_bad++;
            $display("FAIL sb_pop: got %h, required %h", s_out.data, q[0]);
          end
          q.delete(0);
        end
      end
      if (s_flush) q.delete();
      else if (s_in.valid && s_in.ready) q.push_back(s_in.data);
    end
  end

  task automatic s_drv(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    s_in.valid = iv;
    s_in.data = d;
    s_out.ready = ordy;
    s_flush = fl;
    @(negedge clk);
  endtask

  task automatic z_drv(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    z_in.valid = iv;
    z_in.data = d;
    z_out.ready = ordy;
    z_flush = fl;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int p0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_out.valid, s_occ, s_in.ready} !== {1'b1, 2'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_ctl: got v/occ/rdy %b/%0d/%b, required 1/1/1", s_out.valid, s_occ, s_in.ready);
    end
    n_cmp++;
    if (s_out.data !== RST_D) begin
      n_bad++;
      $display("FAIL reset_data: got %h, required %h", s_out.data, RST_D);
    end
    n_cmp++;
    if (s_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d, required 0", s_cnt);
    end
    n_cmp++;
    if ({z_out.valid, z_occ, z_in.ready, z_cnt} !== {1'b0, 2'd0, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_noskid: got v/occ/rdy/cnt %b/%0d/%b/%0d, required 0/0/1/0", z_out.valid, z_occ, z_in.ready, z_cnt);
    end
    p0 = n_pop;
    s_drv(1'b0, '0, 1'b1, 1'b0);
    s_drv(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({s_occ, n_pop - p0} !== {2'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL reset_drain: got occ %0d pops %0d, required 0 and 1", s_occ, n_pop - p0);
    end
  endtask

  task automatic test_stream();
    int p0 = n_pop;
    for (int i = 1; i <= 8; i++) begin
      s_drv(1'b1, 64'(i), 1'b1, 1'b0);
      n_cmp++;
      if (s_in.ready !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_rdy: beat %0d got %b, required 1", i, s_in.ready);
      end
      if (i > 1) begin
        n_cmp++;
        if ({s_out.valid, s_out.data} !== {1'b1, 64'(i - 1)}) begin
          n_bad++;
          $display("FAIL stream_out: got %b/%h, required 1/%h", s_out.valid, s_out.data, 64'(i - 1));
        end
      end
    end
    s_drv(1'b0, '0, 1'b1, 1'b0);
    s_drv(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({s_occ, n_pop - p0} !== {2'd0, 32'd8}) begin
      n_bad++;
      $display("FAIL stream_end: got occ %0d pops %0d, required 0 and 8", s_occ, n_pop - p0);
    end
  endtask

  task automatic test_backpressure();
    int p0 = n_pop;
    s_drv(1'b1, 64'hA, 1'b1, 1'b0);
    s_drv(1'b1, 64'hB, 1'b0, 1'b0);
    n_cmp++;
    if ({s_in.ready, s_occ, s_out.data} !== {1'b1, 2'd1, 64'hA}) begin
      n_bad++;
      $display("FAIL bp_first_stall: got rdy/occ/data %b/%0d/%h, required 1/1/a", s_in.ready, s_occ, s_out.data);
    end
    for (int k = 0; k < 2; k++) begin
      s_drv(1'b1, 64'hC, 1'b0, 1'b0);
      n_cmp++;
      if ({s_in.ready, s_occ, s_out.valid, s_out.data} !== {1'b0, 2'd2, 1'b1, 64'hA}) begin
        n_bad++;
        $display("FAIL bp_full: got rdy/occ/v/data %b/%0d/%b/%h, required 0/2/1/a", s_in.ready, s_occ, s_out.valid, s_out.data);
      end
    end
    s_drv(1'b1, 64'hC, 1'b1, 1'b0);
    n_cmp++;
    if (s_in.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release_rdy: got %b, required 0", s_in.ready);
    end
    s_drv(1'b1, 64'hC, 1'b1, 1'b0);
    n_cmp++;
    if ({s_in.ready, s_out.data} !== {1'b1, 64'hB}) begin
      n_bad++;
      $display("FAIL bp_second: got rdy/data %b/%h, required 1/b", s_in.ready, s_out.data);
    end
    s_drv(1'b0, '0, 1'b1, 1'b0);
    s_drv(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({s_occ, n_pop - p0} !== {2'd0, 32'd3}) begin
      n_bad++;
      $display("FAIL bp_end: got occ %0d pops %0d, required 0 and 3", s_occ, n_pop - p0);
    end
  endtask

  task automatic test_flush_full();
    s_drv(1'b1, 64'hD, 1'b0, 1'b0);
    s_drv(1'b1, 64'hE, 1'b0, 1'b0);
    s_drv(1'b1, 64'hF, 1'b0, 1'b1);
    n_cmp++;
    if ({s_in.ready, s_occ} !== {1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL flush_full_pre: got rdy/occ %b/%0d, required 0/2", s_in.ready, s_occ);
    end
    s_drv(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({s_out.valid, s_in.ready, s_occ, s_cnt} !== {1'b0, 1'b1, 2'd0, 32'd2}) begin
      n_bad++;
      $display("FAIL flush_full: got v/rdy/occ/cnt %b/%b/%0d/%0d, required 0/1/0/2", s_out.valid, s_in.ready, s_occ, s_cnt);
    end
  endtask

  task automatic test_flush_one();
    int p0 = n_pop;
    s_drv(1'b1, 64'h11, 1'b0, 1'b0);
    s_drv(1'b1, 64'h22, 1'b1, 1'b1);
    n_cmp++;
    if ({s_in.ready, s_out.valid, s_out.data} !== {1'b1, 1'b1, 64'h11}) begin
      n_bad++;
      $display("FAIL flush_one_pre: got rdy/v/data %b/%b/%h, required 1/1/11", s_in.ready, s_out.valid, s_out.data);
    end
    s_drv(1'b1, 64'h33, 1'b0, 1'b0);
    n_cmp++;
    if ({s_out.valid, s_in.ready, s_occ, s_cnt, n_pop - p0} !== {1'b0, 1'b1, 2'd0, 32'd3, 32'd1}) begin
      n_bad++;
      $display("FAIL flush_one: got v/rdy/occ/cnt/pops %b/%b/%0d/%0d/%0d, required 0/1/0/3/1", s_out.valid, s_in.ready, s_occ, s_cnt, n_pop - p0);
    end
    s_drv(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if ({s_out.valid, s_out.data} !== {1'b1, 64'h33}) begin
      n_bad++;
      $display("FAIL flush_refill: got %b/%h, required 1/33", s_out.valid, s_out.data);
    end
    s_drv(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_rst_flush();
    int p0;
    s_drv(1'b1, 64'h44, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_flush = 1'b1;
    s_in.data = 64'h55;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_flush = 1'b0;
    s_in.valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_out.valid, s_occ, s_in.ready, s_cnt, s_out.data} !== {1'b1, 2'd1, 1'b1, 32'd0, RST_D}) begin
      n_bad++;
      $display("FAIL rst_flush: got v/occ/rdy/cnt/data %b/%0d/%b/%0d/%h, required 1/1/1/0/%h", s_out.valid, s_occ, s_in.ready, s_cnt, s_out.data, RST_D);
    end
    p0 = n_pop;
    s_drv(1'b0, '0, 1'b1, 1'b0);
    s_drv(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({s_occ, n_pop - p0} !== {2'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL rst_flush_drain: got occ %0d pops %0d, required 0 and 1", s_occ, n_pop - p0);
    end
  endtask

  task automatic test_noskid_flush_sat();
    logic [1:0] exp_cnt = 2'd0;
    for (int k = 0; k < 4; k++) begin
      z_drv(1'b1, 64'h100 + 64'(k), 1'b0, 1'b0);
      n_cmp++;
      if ({z_in.ready, z_out.valid, z_cnt} !== {1'b1, 1'b0, exp_cnt}) begin
        n_bad++;
        $display("FAIL ns_accept: k=%0d got rdy/v/cnt %b/%b/%0d, required 1/0/%0d", k, z_in.ready, z_out.valid, z_cnt, exp_cnt);
      end
      z_drv(1'b1, 64'h200 + 64'(k), 1'b0, 1'b1);
      n_cmp++;
      if ({z_in.ready, z_out.valid, z_occ, z_out.data} !== {1'b0, 1'b1, 2'd1, 64'h100 + 64'(k)}) begin
        n_bad++;
        $display("FAIL ns_held: k=%0d got rdy/v/occ/data %b/%b/%0d/%h, required 0/1/1/%h", k, z_in.ready, z_out.valid, z_occ, z_out.data, 64'h100 + 64'(k));
      end
      exp_cnt = exp_cnt == 2'd3 ? 2'd3 : exp_cnt + 2'd1;
    end
    z_drv(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({z_cnt, z_occ} !== {2'd3, 2'd0}) begin
      n_bad++;
      $display("FAIL ns_sat: got cnt/occ %0d/%0d, required 3/0", z_cnt, z_occ);
    end
  endtask

  task automatic test_noskid_stream();
    for (int i = 1; i <= 4; i++) begin
      z_drv(1'b1, 64'h300 + 64'(i), 1'b1, 1'b0);
      n_cmp++;
      if (z_in.ready !== 1'b1) begin
        n_bad++;
        $display("FAIL ns_stream_rdy: beat %0d got %b, required 1", i, z_in.ready);
      end
      if (i > 1) begin
        n_cmp++;
        if ({z_out.valid, z_out.data} !== {1'b1, 64'h300 + 64'(i - 1)}) begin
          n_bad++;
          $display("FAIL ns_stream_out: got %b/%h, required 1/%h", z_out.valid, z_out.data, 64'h300 + 64'(i - 1));
        end
      end
    end
    z_drv(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if ({z_out.valid, z_out.data} !== {1'b1, 64'h304}) begin
      n_bad++;
      $display("FAIL ns_stream_last: got %b/%h, required 1/304", z_out.valid, z_out.data);
    end
    z_drv(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (z_occ !== 2'd0) begin
      n_bad++;
      $display("FAIL ns_stream_end: got occ %0d, required 0", z_occ);
    end
  endtask

  initial begin
    s_in.valid = 1'b0;
    s_in.data = '0;
    s_out.ready = 1'b0;
    s_flush = 1'b0;
    z_in.valid = 1'b0;
    z_in.data = '0;
    z_out.ready = 1'b0;
    z_flush = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_one();
    test_rst_flush();
    test_noskid_flush_sat();
    test_noskid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
